// File: rtl/dl_arb_pkg.sv
// Shared types for the download/CPU RAM arbiter.
// State encoding, FIFO entry layout and default sizing.
package dl_arb_pkg;

    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DL_ADDR_W          = 25;

    typedef enum logic [2:0] {
        IDLE,
        CPU,
        DL,
        FLUSH,
        RELEASE
    } arb_state_t;

    typedef struct packed {
        logic [DL_ADDR_W-1:0] addr;
        logic [7:0]           data;
    } dl_entry_t;

endpackage

// File: rtl/dl_fifo.sv
// Download write buffer: small synchronous FIFO of dl_entry_t.
// A pop on a full FIFO frees the slot for a same-cycle push.
module dl_fifo
    import dl_arb_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  dl_entry_t din,
    output dl_entry_t dout,
    output logic      full,
    output logic      empty,
    output logic [PW:0] count
);

    localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

    dl_entry_t         mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Entry storage; pointers alone define validity, so no reset needed
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking, wrapping modulo DEPTH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dl_ram_arbiter.sv
// Single RAM port arbiter between the boot/PRG downloader and the Z80 bus.
// Optional DL_CHECKSUM_EN adds a 16-bit running sum of downloaded bytes.
module dl_ram_arbiter
    import dl_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int ADDR_W     = DL_ADDR_W,
    parameter int CPU_ADDR_W = 16,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dl_wr,
    input  logic [ADDR_W-1:0]     dl_addr,
    input  logic [7:0]            dl_data,
    input  logic                  dl_downloading,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [CPU_ADDR_W-1:0] cpu_addr,
    input  logic [7:0]            cpu_dout,
    output logic [7:0]            cpu_din,
    output logic                  cpu_wait,
    output logic                  ram_req,
    output logic                  ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [7:0]            ram_din,
    input  logic [7:0]            ram_dout,
    input  logic                  ram_ack,
    output logic                  dl_overflow,
    output logic [15:0]           dl_sum
);

    arb_state_t            state;
    logic                  dl_prev;
    logic                  dl_rise;

    dl_entry_t             fifo_in;
    dl_entry_t             fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  draining;

    logic                  pend_vld;
    logic                  pend_we;
    logic [CPU_ADDR_W-1:0] pend_addr;
    logic [7:0]            pend_dout;

    assign dl_rise  = dl_downloading & ~dl_prev;
    assign draining = (state == DL) || (state == FLUSH);
    assign pop      = draining & ram_req & ram_ack;
    assign push     = dl_wr & (~fifo_full | pop);
    assign drop     = dl_wr & fifo_full & ~pop;
    assign fifo_in  = '{addr: DL_ADDR_W'(dl_addr), data: dl_data};

    dl_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_in),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Arbitration FSM; every bus-facing output is registered here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cpu_din   <= '0;
            cpu_wait  <= 1'b0;
            ram_req   <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            pend_vld  <= 1'b0;
            pend_we   <= 1'b0;
            pend_addr <= '0;
            pend_dout <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dl_downloading) begin
                        state    <= DL;
                        cpu_wait <= 1'b1;
                        if (cpu_req) begin
                            pend_vld  <= 1'b1;
                            pend_we   <= cpu_we;
                            pend_addr <= cpu_addr;
                            pend_dout <= cpu_dout;
                        end
                    end else if (cpu_req) begin
                        state    <= CPU;
                        cpu_wait <= 1'b1;
                        ram_req  <= 1'b1;
                        ram_we   <= cpu_we;
                        ram_addr <= ADDR_W'(cpu_addr);
                        ram_din  <= cpu_dout;
                    end
                end
                CPU: begin
                    if (ram_ack) begin
                        if (!ram_we)
                            cpu_din <= ram_dout;
                        ram_req  <= 1'b0;
                        ram_we   <= 1'b0;
                        cpu_wait <= 1'b0;
                        state    <= IDLE;
                    end
                end
                DL, FLUSH: begin
                    cpu_wait <= 1'b1;
                    if (cpu_req && !pend_vld) begin
                        pend_vld  <= 1'b1;
                        pend_we   <= cpu_we;
                        pend_addr <= cpu_addr;
                        pend_dout <= cpu_dout;
                    end
                    if (ram_req) begin
                        if (ram_ack) begin
                            ram_req <= 1'b0;
                            ram_we  <= 1'b0;
                        end
                    end else if (!fifo_empty) begin
                        ram_req  <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= ADDR_W'(fifo_head.addr);
                        ram_din  <= fifo_head.data;
                    end else if (state == FLUSH && fifo_count == '0) begin
                        state <= RELEASE;
                    end
                    if (state == DL && !dl_downloading)
                        state <= FLUSH;
                end
                RELEASE: begin
                    if (pend_vld) begin
                        state    <= CPU;
                        ram_req  <= 1'b1;
                        ram_we   <= pend_we;
                        ram_addr <= ADDR_W'(pend_addr);
                        ram_din  <= pend_dout;
                        pend_vld <= 1'b0;
                    end else if (cpu_req) begin
                        state    <= CPU;
                        ram_req  <= 1'b1;
                        ram_we   <= cpu_we;
                        ram_addr <= ADDR_W'(cpu_addr);
                        ram_din  <= cpu_dout;
                    end else begin
                        cpu_wait <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    ram_req  <= 1'b0;
                    cpu_wait <= 1'b0;
                end
            endcase
        end
    end

    // Session edge detect and sticky drop flag, re-armed per session
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dl_prev     <= 1'b0;
            dl_overflow <= 1'b0;
        end else begin
            dl_prev <= dl_downloading;
            if (dl_rise)
                dl_overflow <= drop;
            else if (drop)
                dl_overflow <= 1'b1;
        end
    end

`ifdef DL_CHECKSUM_EN
    // Running sum of bytes acknowledged by RAM, restarted per session
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dl_sum <= '0;
        else if (dl_rise || pop)
            dl_sum <= (dl_rise ? 16'h0000 : dl_sum)
                    + (pop ? {8'h00, fifo_head.data} : 16'h0000);
    end
`else
    assign dl_sum = '0;
`endif

endmodule

// File: tb/tb_dl_ram_arbiter.sv
// Directed self-checking bench for dl_ram_arbiter.
// Behavioural RAM with programmable ack latency logs every completed access.
module tb_dl_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        dl_wr;
    logic [24:0] dl_addr;
    logic [7:0]  dl_data;
    logic        dl_downloading;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_wait;
    logic        ram_req;
    logic        ram_we;
    logic [24:0] ram_addr;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic        ram_ack;
    logic        dl_overflow;
    logic [15:0] dl_sum;

    int checks = 0;
    int errors = 0;

    int          ram_lat;
    bit          ack_en;
    logic [7:0]  rd_val;
    int          lat_cnt;
    logic [24:0] log_addr [$];
    logic [7:0]  log_data [$];
    logic        log_we   [$];

    always #5 clk = ~clk;

    dl_ram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .dl_wr          (dl_wr),
        .dl_addr        (dl_addr),
        .dl_data        (dl_data),
        .dl_downloading (dl_downloading),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .cpu_din        (cpu_din),
        .cpu_wait       (cpu_wait),
        .ram_req        (ram_req),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_din        (ram_din),
        .ram_dout       (ram_dout),
        .ram_ack        (ram_ack),
        .dl_overflow    (dl_overflow),
        .dl_sum         (dl_sum)
    );

    // RAM model: acks ram_lat cycles after seeing a request, one-cycle pulse
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_ack  <= 1'b0;
            ram_dout <= 8'h00;
            lat_cnt  <= 0;
        end else begin
            ram_ack <= 1'b0;
            if (ram_req && !ram_ack && ack_en) begin
                if (lat_cnt + 1 >= ram_lat) begin
                    ram_ack  <= 1'b1;
                    ram_dout <= rd_val;
                    lat_cnt  <= 0;
                    log_addr.push_back(ram_addr);
                    log_data.push_back(ram_din);
                    log_we.push_back(ram_we);
                end else begin
                    lat_cnt <= lat_cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        log_we.delete();
    endtask

    task automatic wait_log(input int n, input string tag);
        int k = 0;
        while (log_addr.size() < n && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_log_reached"}, 32'(log_addr.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (cpu_wait && k < 400) begin
            tick();
            k++;
        end
        chk({tag, "_released"}, 32'(cpu_wait), 32'd0);
    endtask

    task automatic dl_byte(input logic [24:0] a, input logic [7:0] d);
        dl_wr   = 1'b1;
        dl_addr = a;
        dl_data = d;
        tick();
        dl_wr   = 1'b0;
    endtask

    logic [15:0] exp_sum;
    int          n;
    int          wait_low;

    initial begin
        reset          = 1'b1;
        dl_wr          = 1'b0;
        dl_addr        = '0;
        dl_data        = '0;
        dl_downloading = 1'b0;
        cpu_req        = 1'b0;
        cpu_we         = 1'b0;
        cpu_addr       = '0;
        cpu_dout       = '0;
        ram_lat        = 1;
        ack_en         = 1'b1;
        rd_val         = 8'h00;
        tick();
        tick();

        // Reset state
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        chk("rst_ram_req", 32'(ram_req), 32'd0);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", 32'(ram_din), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din), 32'd0);
        chk("rst_ovf", 32'(dl_overflow), 32'd0);
        chk("rst_sum", 32'(dl_sum), 32'd0);
        reset = 1'b0;
        tick();

        // CPU read, RAM latency 3
        ram_lat  = 3;
        rd_val   = 8'hA5;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 16'h8000;
        tick();
        cpu_req = 1'b0;
        chk("t1_wait_rise", 32'(cpu_wait), 32'd1);
        chk("t1_ram_req", 32'(ram_req), 32'd1);
        chk("t1_ram_we", 32'(ram_we), 32'd0);
        chk("t1_ram_addr", 32'(ram_addr), 32'h8000);
        n = 0;
        wait_low = 0;
        while (!ram_ack && n < 20) begin
            tick();
            n++;
            if (!cpu_wait) wait_low++;
        end
        chk("t1_ack_lat", 32'(n), 32'd3);
        chk("t1_wait_held", 32'(wait_low), 32'd0);
        tick();
        chk("t1_wait_fall", 32'(cpu_wait), 32'd0);
        chk("t1_cpu_din", 32'(cpu_din), 32'hA5);
        chk("t1_req_drop", 32'(ram_req), 32'd0);
        clear_log();
        ram_lat = 1;

        // Six download bytes, one per two cycles
        dl_downloading = 1'b1;
        tick();
        chk("t2_wait_rise", 32'(cpu_wait), 32'd1);
        wait_low = 0;
        for (int i = 0; i < 6; i++) begin
            dl_byte(25'h100 + 25'(i), 8'h10 + 8'(i));
            if (!cpu_wait) wait_low++;
            tick();
            if (!cpu_wait) wait_low++;
        end
        dl_downloading = 1'b0;
        chk("t2_wait_held", 32'(wait_low), 32'd0);
        wait_idle("t2");
        chk("t2_count", 32'(log_addr.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t2_addr%0d", i), 32'(log_addr[i]), 32'h100 + 32'(i));
            chk($sformatf("t2_data%0d", i), 32'(log_data[i]), 32'h10 + 32'(i));
            chk($sformatf("t2_we%0d", i), 32'(log_we[i]), 32'd1);
        end
        chk("t2_ovf", 32'(dl_overflow), 32'd0);
`ifdef DL_CHECKSUM_EN
        exp_sum = 16'h006F;
`else
        exp_sum = 16'h0000;
`endif
        chk("t2_sum", 32'(dl_sum), 32'(exp_sum));
        clear_log();

        // Overflow: five back-to-back bytes with RAM stalled
        ack_en         = 1'b0;
        dl_downloading = 1'b1;
        tick();
        for (int i = 0; i < 5; i++)
            dl_byte(25'h200 + 25'(i), 8'h20 + 8'(i));
        chk("t3_ovf_set", 32'(dl_overflow), 32'd1);
        chk("t3_req_held", 32'(ram_req), 32'd1);
        chk("t3_head_addr", 32'(ram_addr), 32'h200);
        ack_en         = 1'b1;
        dl_downloading = 1'b0;
        wait_idle("t3");
        chk("t3_count", 32'(log_addr.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t3_addr%0d", i), 32'(log_addr[i]), 32'h200 + 32'(i));
            chk($sformatf("t3_data%0d", i), 32'(log_data[i]), 32'h20 + 32'(i));
        end
        chk("t3_ovf_sticky", 32'(dl_overflow), 32'd1);
        clear_log();

        // Flush: session ends with three bytes queued
        ack_en         = 1'b0;
        dl_downloading = 1'b1;
        tick();
        chk("t4_ovf_clear", 32'(dl_overflow), 32'd0);
        for (int i = 0; i < 3; i++)
            dl_byte(25'h300 + 25'(i), 8'h30 + 8'(i));
        dl_downloading = 1'b0;
        ack_en         = 1'b1;
        wait_log(3, "t4");
        chk("t4_wait_ack", 32'(cpu_wait), 32'd1);
        tick();
        chk("t4_wait_pop", 32'(cpu_wait), 32'd1);
        tick();
        chk("t4_wait_release", 32'(cpu_wait), 32'd1);
        tick();
        chk("t4_wait_idle", 32'(cpu_wait), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_addr%0d", i), 32'(log_addr[i]), 32'h300 + 32'(i));
            chk($sformatf("t4_data%0d", i), 32'(log_data[i]), 32'h30 + 32'(i));
        end
        clear_log();

        // CPU write collides with session start; served after drain
        cpu_req        = 1'b1;
        cpu_we         = 1'b1;
        cpu_addr       = 16'h9000;
        cpu_dout       = 8'h3C;
        dl_downloading = 1'b1;
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        chk("t5_wait", 32'(cpu_wait), 32'd1);
        chk("t5_no_cpu_req", 32'(ram_req), 32'd0);
        dl_byte(25'h400, 8'h40);
        dl_byte(25'h401, 8'h41);
        dl_downloading = 1'b0;
        wait_log(3, "t5");
        chk("t5_dl0_addr", 32'(log_addr[0]), 32'h400);
        chk("t5_dl1_addr", 32'(log_addr[1]), 32'h401);
        chk("t5_cpu_addr", 32'(log_addr[2]), 32'h9000);
        chk("t5_cpu_data", 32'(log_data[2]), 32'h3C);
        chk("t5_cpu_we", 32'(log_we[2]), 32'd1);
        chk("t5_wait_at_ack", 32'(cpu_wait), 32'd1);
        tick();
        chk("t5_wait_fall", 32'(cpu_wait), 32'd0);
        clear_log();

        // Reset in the middle of an outstanding download write
        ack_en         = 1'b0;
        dl_downloading = 1'b1;
        tick();
        dl_byte(25'h500, 8'h55);
        tick();
        chk("t6_req_before", 32'(ram_req), 32'd1);
        reset          = 1'b1;
        dl_downloading = 1'b0;
        #1;
        chk("t6_req_async", 32'(ram_req), 32'd0);
        chk("t6_wait_async", 32'(cpu_wait), 32'd0);
        tick();
        reset  = 1'b0;
        ack_en = 1'b1;
        repeat (10) tick();
        chk("t6_no_retry", 32'(log_addr.size()), 32'd0);
        chk("t6_idle", 32'(cpu_wait), 32'd0);

`ifdef DL_CHECKSUM_EN
        // 300 x 0xFF wraps the 16-bit sum to 0x2AD4
        clear_log();
        dl_downloading = 1'b1;
        tick();
        for (int i = 0; i < 300; i++) begin
            dl_byte(25'h1000 + 25'(i), 8'hFF);
            repeat (3) tick();
        end
        dl_downloading = 1'b0;
        wait_idle("t7");
        chk("t7_count", 32'(log_addr.size()), 32'd300);
        chk("t7_sum", 32'(dl_sum), 32'h2AD4);
        chk("t7_ovf", 32'(dl_overflow), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dl_ram_arbiter.md
Name: dl_ram_arbiter

Overview:
- Sits directly downstream of the boot/PRG downloader.
- Owns the single RAM port and arbitrates between download writes (wr/addr/data/downloading) and the Z80 CPU bus.
- Buffers download bytes in a small FIFO and stalls the CPU (WAIT) for the whole download plus drain.
- Hands the RAM back to the CPU only after every buffered byte has been acknowledged.

Parameters:
- FIFO_DEPTH, 4, download write buffer entries; power of two, min 2.
- ADDR_W, 25, RAM/download address width.
- CPU_ADDR_W, 16, CPU address width; zero-extended to ADDR_W.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_wr  in  1  download write strobe; each high cycle = one byte.
- dl_addr  in  ADDR_W  download byte address.
- dl_data  in  8  download byte.
- dl_downloading  in  1  download session active (level).
- cpu_req  in  1  CPU access request pulse (MREQ qualified).
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  CPU_ADDR_W  CPU address; sampled with cpu_req.
- cpu_dout  in  8  CPU write data; sampled with cpu_req.
- cpu_din  out  8  read data returned to the CPU.
- cpu_wait  out  1  high = CPU must hold its bus cycle.
- ram_req  out  1  RAM request, held until ram_ack.
- ram_we  out  1  RAM write enable; valid with ram_req.
- ram_addr  out  ADDR_W  RAM address.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data; valid on the ram_ack cycle.
- ram_ack  in  1  one-cycle completion pulse.
- dl_overflow  out  1  sticky: a download byte was dropped.
- dl_sum  out  16  download checksum (see Optional Feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty.
- FIFO push: on every clk with dl_wr=1 and FIFO not full, push {dl_addr, dl_data}.
- FIFO full: if dl_wr=1 and the FIFO is full, the byte is dropped and dl_overflow is set.
  - Push and pop in the same cycle on a full FIFO: the pop frees the slot, so the push succeeds.
- dl_overflow clears only on reset or on a rising edge of dl_downloading.
- FIFO pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- State machine:
  - IDLE:
    - dl_downloading=1 -> DL.
    - else cpu_req=1 -> latch {we, addr, dout}, cpu_wait=1, -> CPU.
    - DL takes priority when both occur in the same cycle; the CPU request stays latched and is served after RELEASE.
  - CPU:
    - ram_req=1 with latched fields.
    - On ram_ack: read captures ram_dout into cpu_din; drop ram_req; cpu_wait=0 next cycle; -> IDLE.
    - dl_downloading rising here does not abort; DL is entered after ack.
  - DL:
    - cpu_wait=1.
    - If FIFO not empty and no ram_req outstanding: assert ram_req/ram_we=1 with the head entry.
    - On ram_ack: pop, deassert ram_req for at least one cycle.
    - dl_downloading=0 -> FLUSH.
  - FLUSH: same as DL; when FIFO empty and no ram_req outstanding -> RELEASE.
  - RELEASE:
    - One settle cycle, cpu_wait still 1.
    - Then serve any latched CPU request (-> CPU), else cpu_wait=0 -> IDLE.
- cpu_wait is registered.
  - It asserts the cycle after cpu_req in IDLE.
  - It asserts the cycle after dl_downloading rises.
- Minimum CPU latency: req -> ram_req +1 cycle; ack -> cpu_wait low +1 cycle.
- Address width: cpu_addr is zero-extended; dl_addr passes through unmodified.
- Reset mid-operation: state returns to IDLE, FIFO is flushed, ram_req drops immediately; no partial write is retried.

Optional Feature:
- Macro: DL_CHECKSUM_EN.
- Defined:
  - dl_sum is a 16-bit wrapping sum of every byte popped and acknowledged to RAM.
  - Cleared on the rising edge of dl_downloading.
  - Holds its value after RELEASE.
- Undefined: dl_sum tied to 0; no adder logic.

Decomposition:
- Package dl_arb_pkg holds:
  - state enum {IDLE, CPU, DL, FLUSH, RELEASE};
  - dl_entry_t struct {addr[ADDR_W], data[8]};
  - localparam DEFAULT_FIFO_DEPTH=4.
- Sub-module dl_fifo: synchronous FIFO of dl_entry_t with push/pop/full/empty/count, async active-high reset.

Test Plan:
- CPU read, no download: cpu_req, we=0, addr=16'h8000; RAM acks after 3 cycles with 8'hA5 -> cpu_din=8'hA5, cpu_wait high exactly from req+1 until ack+1.
- Download 6 bytes at 25'h000100.., one per 2 cycles, RAM ack latency 1 -> ram writes in order at 0x100..0x105, dl_overflow=0, cpu_wait=1 throughout.
- Overflow: RAM ack withheld, dl_wr high for 5 consecutive cycles (depth 4) -> 4 bytes written after ack resumes, the 5th dropped, dl_overflow=1 until next dl_downloading rise.
- Flush: dl_downloading falls with 3 bytes queued -> all 3 written, one RELEASE cycle, then cpu_wait=0.
- CPU and download simultaneous: cpu_req write 8'h3C @16'h9000 in the same cycle dl_downloading rises -> download drained first, then the CPU write is issued after RELEASE.
- DL_CHECKSUM_EN: bytes 8'hFF x 300 -> dl_sum=16'h2AD4 (76500 mod 65536); without the macro, dl_sum=0.
